// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg - shared types and helpers for the UART receive engine.
//   rx_state_e      : receive FSM states
//   MIN_DATA_BITS   : smallest legal data_bits value
//   rx_cfg_t        : frame configuration latched at start-bit confirm
//   clamp_data_bits : forces a requested data width into the legal range
//   parity_mismatch : parity check of a received frame
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic [3:0] MIN_DATA_BITS = 4'd5;

   typedef struct packed {
      logic [3:0] data_bits;
      logic       parity_en;
      logic       parity_odd;
      logic       two_stop;
   } rx_cfg_t;

   function automatic logic [3:0] clamp_data_bits(input logic [3:0] req,
                                                  input logic [3:0] max_bits);
      logic [3:0] res;
      if (req < MIN_DATA_BITS) begin
         res = MIN_DATA_BITS;
      end else if (req > max_bits) begin
         res = max_bits;
      end else begin
         res = req;
      end
      return res;
   endfunction

   // data_xor is the XOR of all received data bits; the total including the
   // parity sample must come out equal to parity_odd.
   function automatic logic parity_mismatch(input logic data_xor,
                                            input logic sample,
                                            input logic odd);
      return ((data_xor ^ sample) != odd);
   endfunction

endpackage

// File: rtl/uart_rx_engine_sampler.sv
// uart_rx_sampler - input synchroniser, oversample tick counter and mid-bit
// sample strobe for the UART receive engine.
// Optional feature macro: UART_RX_MAJORITY_EN (2-of-3 majority sampling).
// Ports:
//   pclk, presetn : clock, asynchronous active-low reset
//   uart_rxd      : raw asynchronous serial line (idle high)
//   baud_tick     : OVERSAMPLE pulses per bit period
//   cnt_clr       : clears the tick counter (takes priority over baud_tick)
//   half_mode     : 1 while confirming the start bit (half-bit decision point)
//   rxs           : synchronised line value
//   sample_stb    : one-cycle strobe, a bit decision is available
//   sample_val    : decided bit value, qualified by sample_stb
//   sample_noise  : (macro only) the three samples of this bit disagreed
module uart_rx_sampler #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic pclk,
   input  logic presetn,
   input  logic uart_rxd,
   input  logic baud_tick,
   input  logic cnt_clr,
   input  logic half_mode,
   output logic rxs,
   output logic sample_stb,
`ifdef UART_RX_MAJORITY_EN
   output logic sample_noise,
`endif
   output logic sample_val
);

   localparam int TW = $clog2(OVERSAMPLE);

   // With majority voting the decision is taken one tick after mid-bit, once
   // the mid+1 sample exists; the counter is cleared there, so later bits
   // keep the same mid+1 alignment.
`ifdef UART_RX_MAJORITY_EN
   localparam int HALF_PT = OVERSAMPLE / 2;
`else
   localparam int HALF_PT = OVERSAMPLE / 2 - 1;
`endif
   localparam logic [TW-1:0] T_HALF = TW'(HALF_PT);
   localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [TW-1:0]          tcnt_r;
   logic [TW-1:0]          dec_pt_s;

   // Synchroniser chain, resets to the idle line level.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync_r <= {SYNC_STAGES{1'b1}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], uart_rxd};
      end
   end

   assign rxs = sync_r[SYNC_STAGES-1];

   // Oversample tick counter, wraps at OVERSAMPLE-1.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tcnt_r <= {TW{1'b0}};
      end else if (cnt_clr) begin
         tcnt_r <= {TW{1'b0}};
      end else if (baud_tick) begin
         tcnt_r <= (tcnt_r == T_FULL) ? {TW{1'b0}} : tcnt_r + TW'(1);
      end
   end

   // Decision point: half a bit into the start bit, then every full bit.
   always_comb begin
      if (half_mode) begin
         dec_pt_s = T_HALF;
      end else begin
         dec_pt_s = T_FULL;
      end
   end

   assign sample_stb = baud_tick & (tcnt_r == dec_pt_s);

`ifdef UART_RX_MAJORITY_EN
   logic samp_a_r;
   logic samp_b_r;

   // Capture the two samples preceding the decision tick.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         samp_a_r <= 1'b1;
         samp_b_r <= 1'b1;
      end else if (baud_tick) begin
         if (tcnt_r == dec_pt_s - TW'(2)) samp_a_r <= rxs;
         if (tcnt_r == dec_pt_s - TW'(1)) samp_b_r <= rxs;
      end
   end

   assign sample_val   = (samp_a_r & samp_b_r) | (samp_a_r & rxs) | (samp_b_r & rxs);
   assign sample_noise = ~((samp_a_r == samp_b_r) & (samp_b_r == rxs));
`else
   assign sample_val = rxs;
`endif

endmodule

// File: rtl/uart_rx_engine.sv
// uart_rx_engine - UART receive engine: deframes the serial line into data
// words with parity, framing and break status.
// Optional feature macro: UART_RX_MAJORITY_EN (adds noise_err output).
// Ports:
//   pclk, presetn  : clock, asynchronous active-low reset
//   rx_en          : receiver enable; low aborts any frame in progress
//   uart_rxd       : asynchronous serial input, idle high
//   baud_tick      : OVERSAMPLE pulses per bit period
//   data_bits, parity_en, parity_odd, two_stop : frame configuration,
//                    latched at start-bit confirm
//   rx_data        : received word, right-justified, upper bits zero
//   rx_valid       : one-cycle pulse qualifying rx_data and the flags
//   parity_err, frame_err, break_det : frame status, held until next rx_valid
//   noise_err      : (macro only) some bit's three samples disagreed
//   busy           : FSM not IDLE
module uart_rx_engine
   import uart_rx_pkg::*;
#(
   parameter int OVERSAMPLE  = 16,
   parameter int MAX_DATA_W  = 9,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  rx_en,
   input  logic                  uart_rxd,
   input  logic                  baud_tick,
   input  logic [3:0]            data_bits,
   input  logic                  parity_en,
   input  logic                  parity_odd,
   input  logic                  two_stop,
   output logic [MAX_DATA_W-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  break_det,
`ifdef UART_RX_MAJORITY_EN
   output logic                  noise_err,
`endif
   output logic                  busy
);

   localparam logic [3:0] MAX_BITS = 4'(MAX_DATA_W);

   rx_state_e             state_r, state_n;
   rx_cfg_t               cfg_r;
   logic [3:0]            bitcnt_r;
   logic                  stop2_r;      // first of two stop bits already taken
   logic [MAX_DATA_W-1:0] shift_r;
   logic                  perr_acc_r;
   logic                  ferr_acc_r;
   logic                  zero_acc_r;   // every sample of this frame so far low
   logic                  wait_high_r;  // break seen, hold off until line idles
   logic [MAX_DATA_W-1:0] rx_data_r;
   logic                  rx_valid_r, parity_err_r, frame_err_r, break_det_r, busy_r;

   logic rxs_s, sample_stb_s, sample_val_s;
   logic cnt_clr_s, half_mode_s, last_bit_s, frame_done_s;
   logic stop_ferr_s, stop_zero_s;

   assign cnt_clr_s   = (state_r == IDLE) | ((state_r == START) & sample_stb_s);
   assign half_mode_s = (state_r == START);
   assign last_bit_s  = (bitcnt_r == cfg_r.data_bits - 4'd1);
   assign stop_ferr_s = ferr_acc_r | ~sample_val_s;
   assign stop_zero_s = zero_acc_r & ~sample_val_s;

`ifdef UART_RX_MAJORITY_EN
   logic sample_noise_s;
   logic noise_acc_r;
   logic noise_err_r;
`endif

   uart_rx_sampler #(
      .OVERSAMPLE (OVERSAMPLE),
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sampler (
      .pclk        (pclk),
      .presetn     (presetn),
      .uart_rxd    (uart_rxd),
      .baud_tick   (baud_tick),
      .cnt_clr     (cnt_clr_s),
      .half_mode   (half_mode_s),
      .rxs         (rxs_s),
      .sample_stb  (sample_stb_s),
`ifdef UART_RX_MAJORITY_EN
      .sample_noise(sample_noise_s),
`endif
      .sample_val  (sample_val_s)
   );

   // FSM state register.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n;
      end
   end

   // FSM next-state logic; rx_en low overrides everything.
   always_comb begin
      state_n      = state_r;
      frame_done_s = 1'b0;
      if (!rx_en) begin
         state_n = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (!rxs_s && !wait_high_r) state_n = START;
               else                        state_n = IDLE;
            end
            START: begin
               if (sample_stb_s) state_n = sample_val_s ? IDLE : DATA;
               else              state_n = START;
            end
            DATA: begin
               if (sample_stb_s && last_bit_s) state_n = cfg_r.parity_en ? PARITY : STOP;
               else                            state_n = DATA;
            end
            PARITY: begin
               if (sample_stb_s) state_n = STOP;
               else              state_n = PARITY;
            end
            STOP: begin
               if (sample_stb_s && (!cfg_r.two_stop || stop2_r)) begin
                  state_n      = IDLE;
                  frame_done_s = 1'b1;
               end else begin
                  state_n = STOP;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end

   // Frame datapath, status accumulation and registered outputs.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         cfg_r        <= '{data_bits: MIN_DATA_BITS, parity_en: 1'b0, parity_odd: 1'b0, two_stop: 1'b0};
         bitcnt_r     <= 4'd0;
         stop2_r      <= 1'b0;
         shift_r      <= {MAX_DATA_W{1'b0}};
         perr_acc_r   <= 1'b0;
         ferr_acc_r   <= 1'b0;
         zero_acc_r   <= 1'b0;
         wait_high_r  <= 1'b0;
         rx_data_r    <= {MAX_DATA_W{1'b0}};
         rx_valid_r   <= 1'b0;
         parity_err_r <= 1'b0;
         frame_err_r  <= 1'b0;
         break_det_r  <= 1'b0;
         busy_r       <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         noise_acc_r  <= 1'b0;
         noise_err_r  <= 1'b0;
`endif
      end else begin
         rx_valid_r <= 1'b0;
         busy_r     <= (state_n != IDLE);
         if (rxs_s) wait_high_r <= 1'b0;
         if (rx_en && sample_stb_s) begin
`ifdef UART_RX_MAJORITY_EN
            if (state_r != IDLE) noise_acc_r <= noise_acc_r | sample_noise_s;
`endif
            case (state_r)
               START: begin
                  if (!sample_val_s) begin
                     cfg_r.data_bits  <= clamp_data_bits(data_bits, MAX_BITS);
                     cfg_r.parity_en  <= parity_en;
                     cfg_r.parity_odd <= parity_odd;
                     cfg_r.two_stop   <= two_stop;
                     bitcnt_r         <= 4'd0;
                     stop2_r          <= 1'b0;
                     shift_r          <= {MAX_DATA_W{1'b0}};
                     perr_acc_r       <= 1'b0;
                     ferr_acc_r       <= 1'b0;
                     zero_acc_r       <= 1'b1;
`ifdef UART_RX_MAJORITY_EN
                     noise_acc_r      <= sample_noise_s;
`endif
                  end
               end
               DATA: begin
                  shift_r    <= shift_r | (MAX_DATA_W'(sample_val_s) << bitcnt_r);
                  bitcnt_r   <= bitcnt_r + 4'd1;
                  zero_acc_r <= zero_acc_r & ~sample_val_s;
               end
               PARITY: begin
                  perr_acc_r <= parity_mismatch(^shift_r, sample_val_s, cfg_r.parity_odd);
                  zero_acc_r <= zero_acc_r & ~sample_val_s;
               end
               STOP: begin
                  stop2_r    <= 1'b1;
                  ferr_acc_r <= stop_ferr_s;
                  zero_acc_r <= stop_zero_s;
                  if (frame_done_s) begin
                     rx_valid_r   <= 1'b1;
                     rx_data_r    <= shift_r;
                     parity_err_r <= perr_acc_r;
                     frame_err_r  <= stop_ferr_s;
                     break_det_r  <= stop_zero_s & stop_ferr_s;
                     wait_high_r  <= stop_zero_s;
`ifdef UART_RX_MAJORITY_EN
                     noise_err_r  <= noise_acc_r | sample_noise_s;
`endif
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign rx_data    = rx_data_r;
   assign rx_valid   = rx_valid_r;
   assign parity_err = parity_err_r;
   assign frame_err  = frame_err_r;
   assign break_det  = break_det_r;
   assign busy       = busy_r;
`ifdef UART_RX_MAJORITY_EN
   assign noise_err  = noise_err_r;
`endif

endmodule

// File: tb/tb_uart_rx_engine.sv
`timescale 1ns/1ps
// tb_uart_rx_engine - directed, table-driven bench for uart_rx_engine
// (OVERSAMPLE=16, baud_tick every 4 pclk cycles).
module tb_uart_rx_engine;

   localparam int OS       = 16;
   localparam int TDIV     = 4;
   localparam int BIT_CLKS = OS * TDIV;

   logic       pclk = 1'b0;
   logic       presetn = 1'b0;
   logic       rx_en = 1'b0;
   logic       uart_rxd = 1'b1;
   logic       baud_tick = 1'b0;
   logic [3:0] data_bits = 4'd8;
   logic       parity_en = 1'b0;
   logic       parity_odd = 1'b0;
   logic       two_stop = 1'b0;
   logic [8:0] rx_data;
   logic       rx_valid, parity_err, frame_err, break_det, busy;
`ifdef UART_RX_MAJORITY_EN
   logic       noise_err;
`endif

   int errors = 0;
   int checks = 0;
   int valid_cnt = 0;
   int v0;

   uart_rx_engine #(.OVERSAMPLE(16), .MAX_DATA_W(9), .SYNC_STAGES(2)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .rx_en     (rx_en),
      .uart_rxd  (uart_rxd),
      .baud_tick (baud_tick),
      .data_bits (data_bits),
      .parity_en (parity_en),
      .parity_odd(parity_odd),
      .two_stop  (two_stop),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .break_det (break_det),
`ifdef UART_RX_MAJORITY_EN
      .noise_err (noise_err),
`endif
      .busy      (busy)
   );

   always #5 pclk = ~pclk;

   initial begin
      int div = 0;
      forever begin
         @(negedge pclk);
         baud_tick = (div == TDIV - 1);
         div = (div + 1) % TDIV;
      end
   end

   always @(negedge pclk) begin
      if (rx_valid) valid_cnt <= valid_cnt + 1;
   end

   typedef struct {
      string      name;
      logic [3:0] cfg_bits;
      int         tx_bits;
      logic       pe, po, ts;
      logic [8:0] d;
      logic       pb, s1, s2;
      logic [8:0] ed;
      logic       ep, ef, eb;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive_bit(input logic b, input int ticks);
      uart_rxd = b;
      repeat (ticks * TDIV) @(negedge pclk);
   endtask

   // A low final bit is cut short after its middle so the line is idle again
   // before the engine could confirm a new start bit.
   task automatic send_frame(input logic [8:0] d, input int nb, input logic pe, input logic pb,
                             input logic ts, input logic s1, input logic s2);
      logic bits[$];
      bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) bits.push_back(d[i]);
      if (pe) bits.push_back(pb);
      bits.push_back(s1);
      if (ts) bits.push_back(s2);
      foreach (bits[k]) begin
         drive_bit(bits[k], ((k == bits.size() - 1) && (bits[k] == 1'b0)) ? (OS / 2 + 4) : OS);
      end
      uart_rxd = 1'b1;
   endtask

   task automatic gap();
      repeat (2 * BIT_CLKS) @(negedge pclk);
   endtask

   initial begin
      //          name        cfg  tx  pe    po    ts    data    pb    s1    s2    exp     ep    ef    eb
      vecs[0] = '{"8N1_A5",   4'd8,  8, 1'b0, 1'b0, 1'b0, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{"7E2_ok",   4'd7,  7, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{"7E2_bad",  4'd7,  7, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{"9O1_1FF",  4'd9,  9, 1'b1, 1'b1, 1'b0, 9'h1FF, 1'b0, 1'b1, 1'b1, 9'h1FF, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{"8N1_stpl", 4'd8,  8, 1'b0, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{"8N1_00",   4'd8,  8, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1, 1'b1, 9'h000, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{"7E2_stp2", 4'd7,  7, 1'b1, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b1, 1'b0, 9'h03C, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{"clamp_lo", 4'd3,  5, 1'b0, 1'b0, 1'b0, 9'h013, 1'b0, 1'b1, 1'b1, 9'h013, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{"clamp_hi", 4'd15, 9, 1'b0, 1'b0, 1'b0, 9'h155, 1'b0, 1'b1, 1'b1, 9'h155, 1'b0, 1'b0, 1'b0};

      // Reset state
      repeat (5) @(negedge pclk);
      chk("rst_data", 32'(rx_data), 32'h0);
      chk("rst_valid", 32'(rx_valid), 32'h0);
      chk("rst_perr", 32'(parity_err), 32'h0);
      chk("rst_ferr", 32'(frame_err), 32'h0);
      chk("rst_brk", 32'(break_det), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      presetn = 1'b1;
      rx_en   = 1'b1;
      gap();

      // Table-driven frames
      for (int i = 0; i < 9; i++) begin
         v0         = valid_cnt;
         data_bits  = vecs[i].cfg_bits;
         parity_en  = vecs[i].pe;
         parity_odd = vecs[i].po;
         two_stop   = vecs[i].ts;
         send_frame(vecs[i].d, vecs[i].tx_bits, vecs[i].pe, vecs[i].pb, vecs[i].ts, vecs[i].s1, vecs[i].s2);
         gap();
         chk({vecs[i].name, "_nvalid"}, 32'(valid_cnt), 32'(v0 + 1));
         chk({vecs[i].name, "_data"}, 32'(rx_data), 32'(vecs[i].ed));
         chk({vecs[i].name, "_perr"}, 32'(parity_err), 32'(vecs[i].ep));
         chk({vecs[i].name, "_ferr"}, 32'(frame_err), 32'(vecs[i].ef));
         chk({vecs[i].name, "_brk"}, 32'(break_det), 32'(vecs[i].eb));
         chk({vecs[i].name, "_busy"}, 32'(busy), 32'h0);
      end

      data_bits = 4'd8; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;

      // Start-bit glitch: 4 ticks low then high
      v0 = valid_cnt;
      drive_bit(1'b0, 2);
      chk("glitch_busy_hi", 32'(busy), 32'h1);
      drive_bit(1'b0, 2);
      uart_rxd = 1'b1;
      gap();
      chk("glitch_busy_lo", 32'(busy), 32'h0);
      chk("glitch_nvalid", 32'(valid_cnt), 32'(v0));

      // rx_en dropped in the middle of the data bits
      v0 = valid_cnt;
      drive_bit(1'b0, OS);
      drive_bit(1'b1, OS);
      drive_bit(1'b1, OS);
      drive_bit(1'b0, OS / 2);
      rx_en = 1'b0;
      repeat (2) @(negedge pclk);
      chk("abort_busy", 32'(busy), 32'h0);
      uart_rxd = 1'b1;
      gap();
      rx_en = 1'b1;
      gap();
      chk("abort_nvalid", 32'(valid_cnt), 32'(v0));
      chk("abort_data_hold", 32'(rx_data), 32'h155);
      chk("abort_ferr_hold", 32'(frame_err), 32'h0);

      // Asynchronous reset pulse inside the stop bit
      v0 = valid_cnt;
      drive_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) drive_bit(((8'h55 >> i) & 8'h01) != 8'h00, OS);
      drive_bit(1'b1, 4);
      chk("prerst_busy", 32'(busy), 32'h1);
      #3 presetn = 1'b0;
      repeat (3) @(negedge pclk);
      chk("midrst_data", 32'(rx_data), 32'h0);
      chk("midrst_busy", 32'(busy), 32'h0);
      chk("midrst_valid", 32'(rx_valid), 32'h0);
      presetn = 1'b1;
      drive_bit(1'b1, OS - 4);
      gap();
      chk("postrst_nvalid", 32'(valid_cnt), 32'(v0));
      chk("postrst_data", 32'(rx_data), 32'h0);

      // Clean frame after reset
      v0 = valid_cnt;
      send_frame(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      gap();
      chk("clean55_nvalid", 32'(valid_cnt), 32'(v0 + 1));
      chk("clean55_data", 32'(rx_data), 32'h055);
      chk("clean55_ferr", 32'(frame_err), 32'h0);

      // Break: line held low for two frame times
      v0 = valid_cnt;
      uart_rxd = 1'b0;
      repeat (19 * BIT_CLKS) @(negedge pclk);
      chk("brk_nvalid", 32'(valid_cnt), 32'(v0 + 1));
      chk("brk_det", 32'(break_det), 32'h1);
      chk("brk_ferr", 32'(frame_err), 32'h1);
      chk("brk_data", 32'(rx_data), 32'h0);
      chk("brk_perr", 32'(parity_err), 32'h0);
      chk("brk_busy", 32'(busy), 32'h0);
      repeat (BIT_CLKS) @(negedge pclk);
      uart_rxd = 1'b1;
      gap();
      chk("brk_no_retrig", 32'(valid_cnt), 32'(v0 + 1));
      send_frame(9'h0A5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      gap();
      chk("brk_recover_nvalid", 32'(valid_cnt), 32'(v0 + 2));
      chk("brk_recover_data", 32'(rx_data), 32'h0A5);
      chk("brk_recover_brk", 32'(break_det), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
Parametrised UART receive engine. It takes the raw serial line and an oversample tick from the baud generator, and produces deframed data words with error status.
- Runtime-configurable frame: 5-9 data bits, optional even/odd parity, 1 or 2 stop bits.
- Detects framing, parity and break conditions.
- Sits between the baud generator and the RX FIFO in the APB UART.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period; even, >=8
MAX_DATA_W, 9, width of rx_data; upper bound of data_bits
SYNC_STAGES, 2, synchroniser flops on uart_rxd; >=2

Ports:
pclk  input  1  system clock
presetn  input  1  asynchronous active-low reset
rx_en  input  1  receiver enable; low aborts any frame, returns FSM to IDLE
uart_rxd  input  1  asynchronous serial input, idle high
baud_tick  input  1  single-cycle pulse, OVERSAMPLE per bit period
data_bits  input  4  data bits per frame, legal 5..MAX_DATA_W; sampled at start-bit confirm
parity_en  input  1  parity bit present; sampled at start-bit confirm
parity_odd  input  1  1 = odd parity, 0 = even
two_stop  input  1  2 stop bits expected
rx_data  output  MAX_DATA_W  received word, LSB-first assembled, right-justified, upper bits zero
rx_valid  output  1  one-cycle pulse, rx_data and error flags valid
parity_err  output  1  qualified by rx_valid
frame_err  output  1  qualified by rx_valid
break_det  output  1  qualified by rx_valid; all data, parity and stop samples low
busy  output  1  FSM not IDLE

Behaviour:
- Reset (presetn low, asynchronous):
  - FSM goes to IDLE; all counters and the shift register clear.
  - Synchroniser flops reset to 1.
  - All outputs are 0.
- uart_rxd passes through SYNC_STAGES flops; all logic uses the synchronised value rxs.
- Tick counter tcnt is $clog2(OVERSAMPLE) bits. It advances only on baud_tick and wraps at OVERSAMPLE-1.
- IDLE:
  - Condition to leave: rx_en & ~rxs. On that cycle go to START and clear tcnt.
- START:
  - On the baud_tick where tcnt == OVERSAMPLE/2-1, sample rxs.
  - Sample low: latch the config inputs, clear tcnt and the bit count, go to DATA.
  - Sample high: glitch; return to IDLE with no rx_valid.
- DATA:
  - Each time tcnt wraps (mid-bit), shift the sample into bit [bitcnt] and increment bitcnt.
  - After data_bits samples: go to PARITY if parity_en, else STOP.
- PARITY:
  - Sample one bit mid-bit.
  - parity_err = (XOR of data bits ^ sample) != parity_odd.
- STOP:
  - Sample one bit, or two if two_stop.
  - frame_err = 1 if any stop sample is low.
  - At the last stop sample, assert rx_valid for 1 cycle and go to IDLE on the same cycle.
  - A new start edge is recognised from the next cycle.
- Latency: rx_valid occurs in the pclk cycle after the baud_tick at the middle of the last stop bit.
- rx_data and the flags hold their value until the next rx_valid.
- rx_en deassert in any state:
  - Next cycle goes to IDLE; the partial frame is discarded with no rx_valid.
  - rx_data and the flags are not modified.
- Illegal data_bits (<5 or >MAX_DATA_W) is clamped to the nearest legal value when latched.
- break_det: rx_valid with frame_err=1 and all data, parity and stop samples 0.
  - The FSM then stays in IDLE until rxs has returned high (no re-trigger on a held-low line).
- baud_tick asserted in the same cycle as the IDLE to START transition is ignored.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of rxs at ticks mid-1, mid and mid+1.
  - Adds output noise_err (1 bit): set at rx_valid if any bit's three samples disagreed.
  - noise_err resets to 0.
- Undefined: single sample at mid; no noise_err port.

Decomposition:
- Package uart_rx_pkg:
  - state enum rx_state_e {IDLE, START, DATA, PARITY, STOP}
  - MIN_DATA_BITS=5
  - rx_cfg_t struct (data_bits, parity_en, parity_odd, two_stop)
- One sub-module uart_rx_sampler:
  - Contains the synchroniser, the tick counter and the mid-bit sample strobe/value.
  - Holds the majority logic under the macro.
- The FSM and shift register stay in uart_rx_engine.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 -> one rx_valid, rx_data=0x0A5, all errors 0, busy low afterwards.
- 7E2, send 0x3C with correct parity bit 0 -> rx_data=0x03C, parity_err=0; repeat with parity bit 1 -> parity_err=1.
- 9O1, send 0x1FF with correct parity; then 8N1 with stop bit forced low -> frame_err=1, rx_data still captured.
- Start-bit glitch of 4 ticks low then high -> no rx_valid, FSM back in IDLE, busy=0.
- Line held low for 2 frame times -> one rx_valid with break_det=1, frame_err=1, rx_data=0; no second frame until the line goes high.
- rx_en dropped mid-DATA, then an async presetn pulse mid-STOP -> no rx_valid in either case; outputs reset to 0; the next clean frame 0x55 is received correctly.
